// File: rtl/rotary_input.sv
`default_nettype none
// ============================================================================
//  Module   : rotary_input
//  Purpose  : Quadrature rotary encoder front end. Synchronizes and debounces
//             both phases, decodes full detents, queues them in a saturating
//             signed counter and releases at most one step per video frame
//             as the 2-bit rotate_out command.
//  Options  : ROTARY_DEBOUNCE_EN - when defined, each synchronized line is
//             filtered by a DEBOUNCE_CYCLES persistence counter; otherwise
//             the synchronized value feeds the detent decoder directly.
//  Revision : 1.0 - initial release
// ============================================================================
module rotary_input #(
  parameter int DEBOUNCE_CYCLES = 74250,
  parameter int ACTIVE_V        = 720
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enc_a_in,
  input  logic        enc_b_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic [1:0]  rotate_out
);

  localparam logic [9:0] C_ACTIVE_V = 10'(ACTIVE_V);

  // Detent decoder states; CW path walks AB 01,00,10,11 and CCW 10,00,01,11
  typedef enum logic [2:0] {
    ST_REST = 3'd0,
    ST_CW1  = 3'd1,
    ST_CW2  = 3'd2,
    ST_CW3  = 3'd3,
    ST_CCW1 = 3'd4,
    ST_CCW2 = 3'd5,
    ST_CCW3 = 3'd6
  } state_t;

  // Bit 1 carries phase A, bit 0 carries phase B throughout
  logic [1:0]        w_raw;
  logic [1:0]        r_meta;
  logic [1:0]        r_sync;
  logic [1:0]        w_filt;
  state_t            r_state;
  logic              r_cw_evt;
  logic              r_ccw_evt;
  logic              w_strobe;
  logic signed [3:0] r_net;
  logic signed [4:0] w_net_sum;
  logic signed [3:0] w_net_next;
  logic [1:0]        r_rotate;

  assign w_raw = {enc_a_in, enc_b_in};

  // Two-flop synchronizer; lines idle high so reset to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 2'b11;
      r_sync <= 2'b11;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

`ifdef ROTARY_DEBOUNCE_EN
  localparam int C_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_filt;

    // Flip the filtered value only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt  <= '0;
        r_filt <= 1'b1;
      end else if (r_sync[gi] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        r_filt <= r_sync[gi];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + C_CNT_W'(1);
      end
    end

    assign w_filt[gi] = r_filt;
  end
`else
  assign w_filt = r_sync;
`endif

  // Detent decoder: track the Gray sequence and pulse an event when a detent completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_REST;
      r_cw_evt  <= 1'b0;
      r_ccw_evt <= 1'b0;
    end else begin
      r_cw_evt  <= 1'b0;
      r_ccw_evt <= 1'b0;
      case (r_state)
        ST_REST: begin
          case (w_filt)
            2'b01:   r_state <= ST_CW1;
            2'b10:   r_state <= ST_CCW1;
            default: r_state <= ST_REST;
          endcase
        end
        ST_CW1: begin
          case (w_filt)
            2'b00:   r_state <= ST_CW2;
            2'b01:   r_state <= ST_CW1;
            default: r_state <= ST_REST;
          endcase
        end
        ST_CW2: begin
          case (w_filt)
            2'b10:   r_state <= ST_CW3;
            2'b01:   r_state <= ST_CW1;
            2'b00:   r_state <= ST_CW2;
            default: r_state <= ST_REST;
          endcase
        end
        ST_CW3: begin
          case (w_filt)
            2'b11: begin
              r_state  <= ST_REST;
              r_cw_evt <= 1'b1;
            end
            2'b00:   r_state <= ST_CW2;
            2'b10:   r_state <= ST_CW3;
            default: r_state <= ST_REST;
          endcase
        end
        ST_CCW1: begin
          case (w_filt)
            2'b00:   r_state <= ST_CCW2;
            2'b10:   r_state <= ST_CCW1;
            default: r_state <= ST_REST;
          endcase
        end
        ST_CCW2: begin
          case (w_filt)
            2'b01:   r_state <= ST_CCW3;
            2'b10:   r_state <= ST_CCW1;
            2'b00:   r_state <= ST_CCW2;
            default: r_state <= ST_REST;
          endcase
        end
        ST_CCW3: begin
          case (w_filt)
            2'b11: begin
              r_state   <= ST_REST;
              r_ccw_evt <= 1'b1;
            end
            2'b00:   r_state <= ST_CCW2;
            2'b01:   r_state <= ST_CCW3;
            default: r_state <= ST_REST;
          endcase
        end
        default: r_state <= ST_REST;
      endcase
    end
  end

  assign w_strobe = (hcount_in == 11'd0) && (vcount_in == C_ACTIVE_V);

  // Next queue value: consume one step toward zero on strobe (pre-event net), add event, saturate
  always_comb begin
    w_net_sum = {r_net[3], r_net};
    if (w_strobe) begin
      if (r_net > 4'sd0) begin
        w_net_sum = w_net_sum - 5'sd1;
      end else if (r_net < 4'sd0) begin
        w_net_sum = w_net_sum + 5'sd1;
      end
    end
    if (r_cw_evt) begin
      w_net_sum = w_net_sum + 5'sd1;
    end
    if (r_ccw_evt) begin
      w_net_sum = w_net_sum - 5'sd1;
    end
    if (w_net_sum > 5'sd7) begin
      w_net_next = 4'sd7;
    end else if (w_net_sum < -5'sd7) begin
      w_net_next = -4'sd7;
    end else begin
      w_net_next = w_net_sum[3:0];
    end
  end

  // Queue register and per-frame command, which holds between strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_net    <= 4'sd0;
      r_rotate <= 2'b00;
    end else begin
      r_net <= w_net_next;
      if (w_strobe) begin
        if (r_net > 4'sd0) begin
          r_rotate <= 2'b01;
        end else if (r_net < 4'sd0) begin
          r_rotate <= 2'b10;
        end else begin
          r_rotate <= 2'b00;
        end
      end
    end
  end

  assign rotate_out = r_rotate;

endmodule
`default_nettype wire

// File: tb/tb_rotary_input.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rotary_input
//  Purpose  : Directed self-checking bench for rotary_input
//             (DEBOUNCE_CYCLES=4, ACTIVE_V=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rotary_input;

  localparam int C_DEB = 4;
`ifdef ROTARY_DEBOUNCE_EN
  localparam int C_EVT_LAT  = 2 + C_DEB + 1;  // pin edge -> event pulse
  localparam int C_GLITCH_CW1 = 0;
`else
  localparam int C_EVT_LAT  = 2 + 1;
  localparam int C_GLITCH_CW1 = 1;
`endif

  localparam int C_REST = 0;
  localparam int C_CW1  = 1;
  localparam int C_CW2  = 2;

  logic        clk;
  logic        rst;
  logic        enc_a;
  logic        enc_b;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [1:0]  rotate;

  int n_tests;
  int n_fail;
  int cw_cnt;
  int ccw_cnt;

  rotary_input #(
    .DEBOUNCE_CYCLES(C_DEB),
    .ACTIVE_V       (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enc_a_in  (enc_a),
    .enc_b_in  (enc_b),
    .hcount_in (hcount),
    .vcount_in (vcount),
    .rotate_out(rotate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed detent events as seen on the internal pulses
  initial begin
    cw_cnt  = 0;
    ccw_cnt = 0;
  end
  always @(posedge clk) begin
    if (dut.r_cw_evt === 1'b1)  cw_cnt  <= cw_cnt + 1;
    if (dut.r_ccw_evt === 1'b1) ccw_cnt <= ccw_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic hold_ab(input logic a, input logic b, input int n);
    @(posedge clk);
    #1;
    enc_a = a;
    enc_b = b;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic cw_detent();
    hold_ab(1'b0, 1'b1, 20);
    hold_ab(1'b0, 1'b0, 20);
    hold_ab(1'b1, 1'b0, 20);
    hold_ab(1'b1, 1'b1, 20);
  endtask

  task automatic ccw_detent();
    hold_ab(1'b1, 1'b0, 20);
    hold_ab(1'b0, 1'b0, 20);
    hold_ab(1'b0, 1'b1, 20);
    hold_ab(1'b1, 1'b1, 20);
  endtask

  task automatic strobe();
    @(posedge clk);
    #1;
    hcount = 11'd0;
    vcount = 10'd2;
    @(posedge clk);
    #1;
    hcount = 11'd5;
    vcount = 10'd0;
  endtask

  initial begin
    int cw0;
    int ccw0;
    int saw_cw1;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    enc_a   = 1'b1;
    enc_b   = 1'b1;
    hcount  = 11'd5;
    vcount  = 10'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_val("reset_rotate", 32'(rotate), 0);
    check_val("reset_net", 32'(dut.r_net), 0);
    check_val("reset_state", 32'(dut.r_state), C_REST);

    // One clean CW detent, then two frames
    cw_detent();
    @(negedge clk);
    check_val("cw1_net", 32'(dut.r_net), 1);
    strobe();
    @(negedge clk);
    check_val("cw1_rotate", 32'(rotate), 1);
    check_val("cw1_net_after", 32'(dut.r_net), 0);
    strobe();
    @(negedge clk);
    check_val("cw1_rotate_next", 32'(rotate), 0);

    // Three CCW detents in one frame
    repeat (3) ccw_detent();
    @(negedge clk);
    check_val("ccw3_net", 32'(dut.r_net), -3);
    for (int i = 0; i < 3; i++) begin
      strobe();
      @(negedge clk);
      check_val($sformatf("ccw3_rotate_%0d", i), 32'(rotate), 2);
    end
    strobe();
    @(negedge clk);
    check_val("ccw3_rotate_end", 32'(rotate), 0);

    // Ten CW detents saturate at +7, drain over seven frames
    repeat (10) cw_detent();
    @(negedge clk);
    check_val("sat_net", 32'(dut.r_net), 7);
    for (int i = 0; i < 7; i++) begin
      strobe();
      @(negedge clk);
      check_val($sformatf("sat_rotate_%0d", i), 32'(rotate), 1);
    end
    strobe();
    @(negedge clk);
    check_val("sat_rotate_end", 32'(rotate), 0);
    check_val("sat_net_end", 32'(dut.r_net), 0);

    // Three-cycle glitch on A
    cw0     = cw_cnt;
    ccw0    = ccw_cnt;
    saw_cw1 = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      enc_a = (i < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (32'(dut.r_state) == C_CW1) saw_cw1 = 1;
    end
    check_val("glitch_saw_cw1", saw_cw1, C_GLITCH_CW1);
    check_val("glitch_state", 32'(dut.r_state), C_REST);
    check_val("glitch_events", (cw_cnt - cw0) + (ccw_cnt - ccw0), 0);
    check_val("glitch_net", 32'(dut.r_net), 0);
    check_val("glitch_rotate", 32'(rotate), 0);

    // Partial CW then back out
    cw0  = cw_cnt;
    ccw0 = ccw_cnt;
    hold_ab(1'b0, 1'b1, 20);
    @(negedge clk);
    check_val("part_cw1", 32'(dut.r_state), C_CW1);
    hold_ab(1'b0, 1'b0, 20);
    @(negedge clk);
    check_val("part_cw2", 32'(dut.r_state), C_CW2);
    hold_ab(1'b0, 1'b1, 20);
    @(negedge clk);
    check_val("part_back_cw1", 32'(dut.r_state), C_CW1);
    hold_ab(1'b1, 1'b1, 20);
    @(negedge clk);
    check_val("part_rest", 32'(dut.r_state), C_REST);
    check_val("part_events", (cw_cnt - cw0) + (ccw_cnt - ccw0), 0);
    check_val("part_net", 32'(dut.r_net), 0);

    // Event coincident with strobe at net=+1
    cw_detent();
    @(negedge clk);
    check_val("coin_net_pre", 32'(dut.r_net), 1);
    hold_ab(1'b0, 1'b1, 20);
    hold_ab(1'b0, 1'b0, 20);
    hold_ab(1'b1, 1'b0, 20);
    @(posedge clk);
    #1;
    enc_a = 1'b1;
    enc_b = 1'b1;
    repeat (C_EVT_LAT) @(posedge clk);
    #1;
    check_val("coin_evt", 32'(dut.r_cw_evt), 1);
    hcount = 11'd0;
    vcount = 10'd2;
    @(posedge clk);
    #1;
    hcount = 11'd5;
    vcount = 10'd0;
    @(negedge clk);
    check_val("coin_rotate", 32'(rotate), 1);
    check_val("coin_net", 32'(dut.r_net), 1);

    // Asynchronous reset mid-detent
    hold_ab(1'b0, 1'b1, 20);
    hold_ab(1'b0, 1'b0, 10);
    @(negedge clk);
    check_val("rst_pre_state", 32'(dut.r_state), C_CW2);
    rst = 1'b1;
    #1;
    check_val("rst_rotate", 32'(rotate), 0);
    check_val("rst_net", 32'(dut.r_net), 0);
    check_val("rst_state", 32'(dut.r_state), C_REST);
    enc_a = 1'b1;
    enc_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_val("post_rst_rotate", 32'(rotate), 0);
    check_val("post_rst_net", 32'(dut.r_net), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rotary_input.md
# rotary_input

Front-end input stage for the game pipeline. Converts the raw two-phase quadrature signals of the player's rotary encoder into the 2-bit `rotate_in` command consumed by `game_state`. It synchronizes, debounces and decodes full detents, queues them, and releases at most one step per video frame so frame-based game logic never misses a turn. Sits between the board pins and `game_state`, driven by the same pixel clock and video counters.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 74250: cycles a synchronized line must differ from its filtered value before the filtered value flips (1 ms at 74.25 MHz).
- `ACTIVE_V`, default 720: `vcount_in` value marking the start of vertical blanking (frame strobe line).

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: asynchronous, active-high reset.
- `enc_a_in` in 1: encoder phase A, asynchronous, idles high.
- `enc_b_in` in 1: encoder phase B, asynchronous, idles high.
- `hcount_in` in 11: horizontal pixel counter.
- `vcount_in` in 10: vertical line counter.
- `rotate_out` out 2: per-frame command; 00 none, 01 clockwise, 10 counter-clockwise, 11 never driven.

## Operation
- Synchronizer: each encoder line passes through two flops, reset value 1.
- Debounce, per line: counter counts cycles where synchronized value ≠ filtered value. It clears when they are equal. On reaching `DEBOUNCE_CYCLES`, the filtered value takes the synchronized value and the counter clears. Filtered reset value is 1.
- Detent FSM on filtered {A,B}, states REST, CW1, CW2, CW3, CCW1, CCW2, CCW3:
  - REST: 01→CW1; 10→CCW1.
  - CW1: 00→CW2; 11→REST.
  - CW2: 10→CW3; 01→CW1.
  - CW3: 11→REST and emit cw event; 00→CW2.
  - CCW path mirrors CW: 10, 00, 01, 11; the final 11 emits a ccw event.
  - Any other code, including a skipped phase, returns to REST with no event. Unlisted equal-code cases hold state.
- Event: a one-cycle internal pulse, registered, on the cycle the FSM leaves CW3/CCW3.
- Net queue: 4-bit signed `net`, range −7..+7. A cw event adds 1 and a ccw event subtracts 1, each saturating at ±7.
- Frame strobe: `hcount_in == 0 && vcount_in == ACTIVE_V`, one cycle per frame.
- On strobe:
  - `rotate_out` ← 01 if net>0, 10 if net<0, else 00.
  - net moves one step toward 0.
- `rotate_out` holds until the next strobe.
- Strobe and event in the same cycle: the consume step uses the pre-event net. Next net = net − sign(net) + event, then saturates.

## Timing
- Reset values: `rotate_out` = 00, net = 0, FSM = REST, filtered = 11, sync flops = 1, debounce counters = 0.
- Pin edge to filtered change: 2 sync cycles + `DEBOUNCE_CYCLES` cycles.
- Filtered reaching 11 from CW3/CCW3: event pulse on the next cycle, net updated the cycle after.
- Net to output: `rotate_out` changes 1 cycle after the strobe cycle. One step per frame, so a full queue of 7 drains in 7 frames.
- A glitch shorter than `DEBOUNCE_CYCLES` never reaches the FSM.
- Reset mid-rotation discards partial detents and queued steps. Output is 00 immediately and asynchronously.

## Configuration
- `ROTARY_DEBOUNCE_EN` defined: debounce filters active as described.
- `ROTARY_DEBOUNCE_EN` undefined: filtered value = synchronized value, with no counters. Pin-to-FSM latency is 2 cycles. All other behaviour is unchanged.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `ACTIVE_V`=2, with `ROTARY_DEBOUNCE_EN` defined unless stated.
- One clean CW detent (AB 01,00,10,11, 20 cycles each), then a strobe → net=+1 before the strobe; `rotate_out`=01 for one frame, then 00 on the following strobe.
- Three CCW detents within one frame → `rotate_out`=10 on three consecutive strobes, then 00.
- Ten CW detents, no strobe → net saturates at +7; exactly seven frames of 01 follow.
- A-line pulse of 3 cycles → FSM stays REST, net 0, `rotate_out` 00. Repeat with the macro undefined → FSM reaches CW1, then returns to REST, with no event.
- Partial CW (01,00) then back (01,11) → no event. CW2→CW1→REST is observed.
- Event coincident with a strobe at net=+1 → `rotate_out`=01 and net stays +1. Then assert `rst` mid-detent → `rotate_out`=00 immediately, net=0.
